// File: rtl/memory_unit_if.sv
// memory_unit_if: data-memory write port of the memory stage.
//   DMemWAddr_o  word-aligned write address
//   DMemWData_o  lane-aligned write data
//   DMemWMask_o  byte write strobes (all zero means no write)
// master: memory stage (drives the port); slave: data memory.
interface memory_unit_if;
    logic [31:0] DMemWAddr_o;
    logic [31:0] DMemWData_o;
    logic [3:0]  DMemWMask_o;

    modport master (output DMemWAddr_o, output DMemWData_o, output DMemWMask_o);
    modport slave  (input  DMemWAddr_o, input  DMemWData_o, input  DMemWMask_o);
endinterface

// File: rtl/memory_unit.sv
// memory_unit: memory stage of the RV32 pipeline.
// Issues data-memory writes for stores/AMOs, aligns load data, executes Zicsr
// against fflags/frm/fcsr and the cycle/instret counters, and registers the
// MW_ stage (also the second forwarding source for execute).
// Ports:
//   clk_i, reset_i (async, active low)
//   M_stall_i, W_flush_i          stage control
//   EM_*_i                        execute-to-memory pipeline register
//   fflagsSet_i                   FPU flags accrued every cycle
//   dmem_if (master)              data-memory write port
//   csrFRM_o                      current rounding mode
//   MW_*_o                        memory-to-writeback pipeline register
module memory_unit (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        M_stall_i,
    input  logic        W_flush_i,
    input  logic [31:0] EM_PC_i,
    input  logic [31:0] EM_instr_i,
    input  logic        EM_nop_i,
    input  logic        EM_isLoad_i,
    input  logic        EM_isStore_i,
    input  logic        EM_isCSR_i,
    input  logic        EM_isAMO_i,
    input  logic [5:0]  EM_rdId_i,
    input  logic [5:0]  EM_rs1Id_i,
    input  logic [11:0] EM_csrId_i,
    input  logic [2:0]  EM_funct3_i,
    input  logic [31:0] EM_rs2_i,
    input  logic [31:0] EM_Eresult_i,
    input  logic [31:0] EM_addr_i,
    input  logic [31:0] EM_Mdata_i,
    input  logic        EM_wbEnable_i,
    input  logic [4:0]  fflagsSet_i,
    memory_unit_if.master dmem_if,
    output logic [2:0]  csrFRM_o,
    output logic [31:0] MW_PC_o,
    output logic [31:0] MW_instr_o,
    output logic        MW_nop_o,
    output logic [5:0]  MW_rdId_o,
    output logic [31:0] MW_wbData_o,
    output logic        MW_wbEnable_o
);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0033;

    logic [1:0]  byte_off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;
    logic [3:0]  st_mask;
    logic [31:0] st_data;
    logic        mem_we;
    logic        advance;

    logic [7:0]  fcsr_q, fcsr_d;
    logic [63:0] cycle_q, cycle_d;
    logic [63:0] instret_q, instret_d;
    logic [31:0] csr_src, csr_rdata, csr_wdata;
    logic        csr_we;
    logic [31:0] wb_data;

    logic [31:0] mw_pc_q, mw_instr_q, mw_wbdata_q;
    logic [5:0]  mw_rdid_q;
    logic        mw_nop_q, mw_wben_q;
    logic        unused_bits;

    assign byte_off = EM_addr_i[1:0];
    assign advance  = !M_stall_i && !EM_nop_i;

    // Misalignment is deliberately ignored: halfwords use only o[1], words ignore o.
    always_comb begin
        ld_byte = EM_Mdata_i[7:0];
        case (byte_off)
            2'd1:    ld_byte = EM_Mdata_i[15:8];
            2'd2:    ld_byte = EM_Mdata_i[23:16];
            2'd3:    ld_byte = EM_Mdata_i[31:24];
            default: ld_byte = EM_Mdata_i[7:0];
        endcase
        ld_half = byte_off[1] ? EM_Mdata_i[31:16] : EM_Mdata_i[15:0];
        case (EM_funct3_i[1:0])
            2'b00:   load_data = EM_funct3_i[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   load_data = EM_funct3_i[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: load_data = EM_Mdata_i;
        endcase
    end

    always_comb begin
        st_mask = 4'b1111;
        st_data = EM_rs2_i;
        if (EM_isAMO_i) begin
            st_data = EM_Eresult_i;
        end else begin
            case (EM_funct3_i[1:0])
                2'b00: begin
                    st_mask = 4'b0001 << byte_off;
                    st_data = {4{EM_rs2_i[7:0]}};
                end
                2'b01: begin
                    st_mask = byte_off[1] ? 4'b1100 : 4'b0011;
                    st_data = {2{EM_rs2_i[15:0]}};
                end
                default: ;
            endcase
        end
    end

    assign mem_we              = (EM_isStore_i || EM_isAMO_i) && advance;
    assign dmem_if.DMemWAddr_o = {EM_addr_i[31:2], 2'b00};
    assign dmem_if.DMemWData_o = st_data;
    assign dmem_if.DMemWMask_o = mem_we ? st_mask : 4'b0000;

    // funct3[2] selects the immediate (zimm) form of the CSR operand.
    assign csr_src = EM_funct3_i[2] ? {27'b0, EM_rs1Id_i[4:0]} : EM_Eresult_i;

    always_comb begin
        case (EM_csrId_i)
            12'h001: csr_rdata = {27'b0, fcsr_q[4:0]};
            12'h002: csr_rdata = {29'b0, fcsr_q[7:5]};
            12'h003: csr_rdata = {24'b0, fcsr_q};
            12'hC00: csr_rdata = cycle_q[31:0];
            12'hC80: csr_rdata = cycle_q[63:32];
            12'hC02: csr_rdata = instret_q[31:0];
            12'hC82: csr_rdata = instret_q[63:32];
            default: csr_rdata = 32'b0;
        endcase
    end

    always_comb begin
        case (EM_funct3_i[1:0])
            2'b01:   csr_wdata = csr_src;
            2'b10:   csr_wdata = csr_rdata | csr_src;
            2'b11:   csr_wdata = csr_rdata & ~csr_src;
            default: csr_wdata = csr_rdata;
        endcase
    end

    // Set/clear with a zero operand is a pure read and must not write.
    assign csr_we = EM_isCSR_i && advance &&
                    ((EM_funct3_i[1:0] == 2'b01) || (EM_funct3_i[1] && (csr_src != 32'b0)));

    always_comb begin
        fcsr_d = fcsr_q;
        if (csr_we) begin
            case (EM_csrId_i)
                12'h001: fcsr_d[4:0] = csr_wdata[4:0];
                12'h002: fcsr_d[7:5] = csr_wdata[2:0];
                12'h003: fcsr_d      = csr_wdata[7:0];
                default: ;
            endcase
        end
        fcsr_d[4:0] = fcsr_d[4:0] | fflagsSet_i;
    end

    assign cycle_d   = cycle_q + 64'd1;
    assign instret_d = advance ? instret_q + 64'd1 : instret_q;

    always_comb begin
        if (EM_isCSR_i)       wb_data = csr_rdata;
        else if (EM_isLoad_i) wb_data = load_data;
        else if (EM_isAMO_i)  wb_data = EM_Mdata_i;
        else                  wb_data = EM_Eresult_i;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            fcsr_q      <= 8'b0;
            cycle_q     <= 64'b0;
            instret_q   <= 64'b0;
            mw_pc_q     <= 32'b0;
            mw_instr_q  <= NOP_INSTR;
            mw_nop_q    <= 1'b1;
            mw_rdid_q   <= 6'b0;
            mw_wbdata_q <= 32'b0;
            mw_wben_q   <= 1'b0;
        end else begin
            fcsr_q    <= fcsr_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
            if (!M_stall_i) begin
                mw_pc_q     <= EM_PC_i;
                mw_rdid_q   <= EM_rdId_i;
                mw_wbdata_q <= wb_data;
            end
            // Flush bubbles the control fields even while stalled.
            if (W_flush_i) begin
                mw_instr_q <= NOP_INSTR;
                mw_nop_q   <= 1'b1;
                mw_wben_q  <= 1'b0;
            end else if (!M_stall_i) begin
                mw_instr_q <= EM_instr_i;
                mw_nop_q   <= EM_nop_i;
                mw_wben_q  <= EM_wbEnable_i;
            end
        end
    end

    assign csrFRM_o      = fcsr_q[7:5];
    assign MW_PC_o       = mw_pc_q;
    assign MW_instr_o    = mw_instr_q;
    assign MW_nop_o      = mw_nop_q;
    assign MW_rdId_o     = mw_rdid_q;
    assign MW_wbData_o   = mw_wbdata_q;
    assign MW_wbEnable_o = mw_wben_q;

    assign unused_bits = ^{EM_rs1Id_i[5], csr_wdata[31:8]};
endmodule
